// File: rtl/autocorr_pkg.sv
// autocorr_pkg: shared types and defaults for the frame autocorrelation path.
//   state_t      - top-level control states (fill, multiply-accumulate, divide, output)
//   Q15_MAX      - largest positive Q15 value, used for saturation and the R0 output
//   *_DEF        - default frame length, order, sample width and accumulator width
package autocorr_pkg;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_MAC  = 2'd1,
        ST_DIV  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    localparam int unsigned Q15_MAX       = 32767;
    localparam int unsigned FRAME_LEN_DEF = 160;
    localparam int unsigned ORDER_DEF     = 10;
    localparam int unsigned DW_DEF        = 16;
    localparam int unsigned ACC_W_DEF     = 40;
    localparam int unsigned IDX_W         = 4;

endpackage

// File: rtl/autocorr_frame_if.sv
// autocorr_frame_if: sample input stream, result output stream and status flags.
//   sample_in/sample_valid/sample_ready - upstream sample handshake
//   r_out/r_index/r_valid/r_ready       - normalised lag result handshake
//   busy/done                           - engine status
// master = the side that feeds samples and consumes results; slave = the engine.
interface autocorr_frame_if
    import autocorr_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) ();
    logic signed [DW-1:0]    sample_in;
    logic                    sample_valid;
    logic                    sample_ready;
    logic signed [DW-1:0]    r_out;
    logic        [IDX_W-1:0] r_index;
    logic                    r_valid;
    logic                    r_ready;
    logic                    busy;
    logic                    done;

    modport master (
        output sample_in, sample_valid, r_ready,
        input  sample_ready, r_out, r_index, r_valid, busy, done
    );

    modport slave (
        input  sample_in, sample_valid, r_ready,
        output sample_ready, r_out, r_index, r_valid, busy, done
    );
endinterface

// File: rtl/frac_div_serial.sv
// frac_div_serial: serial restoring fractional divider, one quotient bit per cycle.
// Produces quo = floor(num * 2^(QW-1) / den), valid when num < 2*den.
//   clk, rst - clock, async active-high reset
//   start    - load num/den and begin (ignored bits of a running divide are discarded)
//   num, den - unsigned dividend and divisor
//   quo      - unsigned quotient, MSB first; valid while done is high
//   done     - one-cycle pulse after the last quotient bit is formed
module frac_div_serial #(
    parameter int unsigned W  = 40,
    parameter int unsigned QW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  num,
    input  logic [W-1:0]  den,
    output logic [QW-1:0] quo,
    output logic          done
);
    localparam int unsigned CW = $clog2(QW);

    // One extra bit so the doubled remainder never overflows.
    logic [W:0]    rem;
    logic [W-1:0]  den_q;
    logic [CW-1:0] cnt;
    logic          run;
    logic          ge_c;
    logic [W:0]    diff_c;

    assign ge_c   = rem >= {1'b0, den_q};
    assign diff_c = ge_c ? (rem - {1'b0, den_q}) : rem;

    // Iteration: quotient bit = (rem >= den), subtract if set, then double.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem   <= '0;
            den_q <= '0;
            cnt   <= '0;
            run   <= 1'b0;
            quo   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem   <= {1'b0, num};
                den_q <= den;
                cnt   <= '0;
                quo   <= '0;
                run   <= 1'b1;
            end else if (run) begin
                rem <= diff_c << 1;
                quo <= {quo[QW-2:0], ge_c};
                cnt <= cnt + CW'(1);
                if (cnt == CW'(QW - 1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/autocorr_frame.sv
// autocorr_frame: buffers one frame of signed samples, computes lags R0..R[ORDER]
// with one MAC, normalises each to Q15 against R0 and streams them out in lag order.
//   clk, rst - clock, async active-high reset
//   bus      - autocorr_frame_if slave: sample stream in, result stream out, busy/done
module autocorr_frame
    import autocorr_pkg::*;
#(
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
    parameter int unsigned ORDER     = ORDER_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned ACC_W     = ACC_W_DEF
) (
    input logic             clk,
    input logic             rst,
    autocorr_frame_if.slave bus
);
    localparam int unsigned AW = $clog2(FRAME_LEN);
    localparam int unsigned CW = $clog2(FRAME_LEN + 2);
    localparam int unsigned PW = 2 * DW;
    localparam int unsigned KW = IDX_W;

    state_t state, state_nx;
    logic [KW-1:0] k, k_nx;

    logic                    sample_ready_q, r_valid_q, busy_q, done_q;
    logic signed [DW-1:0]    r_out_q;
    logic        [KW-1:0]    r_index_q;
    logic                    r_valid_d, done_d;
    logic signed [DW-1:0]    r_out_d;
    logic        [KW-1:0]    r_index_d;

    logic [AW-1:0]           wr_ptr;
    logic [CW-1:0]           cnt;
    logic signed [DW-1:0]    mem [FRAME_LEN];
    logic signed [DW-1:0]    rd_a, rd_b;
    logic                    rd_v, prod_v;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] prod_ext_c;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] lag_reg [ORDER+1];

    logic                    sample_fire_c, last_sample_c, issue_c, mac_last_c;
    logic                    out_fire_c, r0_zero_c, div_start_c;
    logic [CW-1:0]           lag_len_c;
    logic [KW-1:0]           num_idx_c;
    logic signed [ACC_W-1:0] num_sel_c;
    logic [ACC_W-1:0]        num_abs_c;
    logic [DW-1:0]           div_q, mag_c;
    logic                    div_done;
    logic signed [DW-1:0]    sat_c;

    assign bus.sample_ready = sample_ready_q;
    assign bus.r_valid      = r_valid_q;
    assign bus.r_out        = r_out_q;
    assign bus.r_index      = r_index_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

    assign sample_fire_c = sample_ready_q && bus.sample_valid;
    assign last_sample_c = sample_fire_c && (wr_ptr == AW'(FRAME_LEN - 1));
    assign lag_len_c     = CW'(FRAME_LEN) - CW'(k);
    assign issue_c       = (state == ST_MAC) && (cnt < lag_len_c);
    // Last issue at lag_len-1, RAM read +1, multiplier +1: lag closes at lag_len+1.
    assign mac_last_c    = (state == ST_MAC) && (cnt == lag_len_c + CW'(1));
    assign out_fire_c    = (state == ST_OUT) && r_valid_q && bus.r_ready;
    assign r0_zero_c     = (lag_reg[0] == '0);
    assign prod_ext_c    = {{(ACC_W - PW){prod[PW-1]}}, prod};

    // The divider is loaded on the edge that enters DIV, so the lag to divide is
    // the one k is about to become.
    assign num_idx_c   = (mac_last_c || k == KW'(ORDER)) ? '0 : k + KW'(1);
    assign num_sel_c   = lag_reg[num_idx_c];
    assign num_abs_c   = num_sel_c[ACC_W-1] ? -num_sel_c : num_sel_c;
    assign div_start_c = !r0_zero_c &&
                         ((mac_last_c && k == KW'(ORDER)) || (out_fire_c && k != KW'(ORDER)));

    // Saturate (R0/R0 yields 2^15) and restore the sign of the current lag.
    assign mag_c = (div_q > DW'(Q15_MAX)) ? DW'(Q15_MAX) : div_q;
    assign sat_c = lag_reg[k][ACC_W-1] ? -$signed(mag_c) : $signed(mag_c);

    frac_div_serial #(
        .W  (ACC_W),
        .QW (DW)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start_c),
        .num   (num_abs_c),
        .den   (lag_reg[0]),
        .quo   (div_q),
        .done  (div_done)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_nx  = state;
        k_nx      = k;
        r_valid_d = r_valid_q;
        r_out_d   = r_out_q;
        r_index_d = r_index_q;
        done_d    = 1'b0;
        unique case (state)
            ST_FILL: begin
                if (last_sample_c) begin
                    state_nx = ST_MAC;
                    k_nx     = '0;
                end
            end
            ST_MAC: begin
                if (mac_last_c) begin
                    if (k == KW'(ORDER)) begin
                        state_nx = ST_DIV;
                        k_nx     = '0;
                    end else begin
                        k_nx = k + KW'(1);
                    end
                end
            end
            ST_DIV: begin
                if (r0_zero_c) begin
                    // Silent frame: no divide, R0 reported as full scale.
                    state_nx  = ST_OUT;
                    r_valid_d = 1'b1;
                    r_index_d = k;
                    r_out_d   = (k == '0) ? DW'(Q15_MAX) : '0;
                end else if (div_done) begin
                    state_nx  = ST_OUT;
                    r_valid_d = 1'b1;
                    r_index_d = k;
                    r_out_d   = sat_c;
                end
            end
            ST_OUT: begin
                if (out_fire_c) begin
                    r_valid_d = 1'b0;
                    if (k == KW'(ORDER)) begin
                        state_nx = ST_FILL;
                        k_nx     = '0;
                        done_d   = 1'b1;
                    end else begin
                        state_nx = ST_DIV;
                        k_nx     = k + KW'(1);
                    end
                end
            end
            default: state_nx = ST_FILL;
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_FILL;
            k              <= '0;
            sample_ready_q <= 1'b1;
            r_valid_q      <= 1'b0;
            r_out_q        <= '0;
            r_index_q      <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state          <= state_nx;
            k              <= k_nx;
            sample_ready_q <= (state_nx == ST_FILL);
            r_valid_q      <= r_valid_d;
            r_out_q        <= r_out_d;
            r_index_q      <= r_index_d;
            busy_q         <= (state_nx != ST_FILL);
            done_q         <= done_d;
        end
    end

    // Write pointer, MAC sequencing counter, pipeline valids and accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            cnt    <= '0;
            rd_v   <= 1'b0;
            prod_v <= 1'b0;
            acc    <= '0;
        end else begin
            if (sample_fire_c) begin
                wr_ptr <= last_sample_c ? '0 : wr_ptr + AW'(1);
            end
            cnt    <= (state != ST_MAC || mac_last_c) ? '0 : cnt + CW'(1);
            rd_v   <= issue_c;
            prod_v <= rd_v;
            if (mac_last_c) begin
                acc <= '0;
            end else if (prod_v) begin
                acc <= acc + prod_ext_c;
            end
        end
    end

    // Frame RAM (one write, two registered reads), multiplier and lag store.
    always_ff @(posedge clk) begin
        if (sample_fire_c) begin
            mem[wr_ptr] <= bus.sample_in;
        end
        if (issue_c) begin
            rd_a <= mem[AW'(cnt)];
            rd_b <= mem[AW'(cnt) + AW'(k)];
        end
        prod <= rd_a * rd_b;
        if (mac_last_c) begin
            lag_reg[k] <= acc + prod_ext_c;
        end
    end
endmodule

// File: tb/tb_autocorr_frame.sv
// tb_autocorr_frame: self-checking bench for autocorr_frame. Known frames from a
// vector table, stall/reset sequences, and random frames against an arithmetic model.
module tb_autocorr_frame;
    import autocorr_pkg::*;

    localparam int FL = FRAME_LEN_DEF;
    localparam int NL = ORDER_DEF + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    autocorr_frame_if #(.DW(16)) bus ();

    autocorr_frame dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int pat;
        int e0;
        int e1;
        int e2;
        int e10;
        int space;
        int lat;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_total = 0;
    int last_accept = 0;
    int frame [FL];
    int exp_r [NL];
    int got_val [NL];
    int got_idx [NL];
    vec_t tbl [4];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.done) done_total <= done_total + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // pat: 0 const 1000, 1 alternating +-1000, 2 impulse, 3 zero, 4 random full, 5 random small
    task automatic build_frame(input int pat);
        for (int i = 0; i < FL; i++) begin
            case (pat)
                0:       frame[i] = 1000;
                1:       frame[i] = (i % 2 == 0) ? 1000 : -1000;
                2:       frame[i] = (i == 0) ? 1000 : 0;
                3:       frame[i] = 0;
                4:       frame[i] = int'($urandom_range(0, 65535)) - 32768;
                default: frame[i] = int'($urandom_range(0, 200)) - 100;
            endcase
        end
    endtask

    // Direct definition: R[k] = sum x[n]x[n+k]; out = sign(Rk)*min(floor(|Rk|*2^15/R0), 32767).
    function automatic void compute_model();
        longint r;
        longint mag;
        longint r0;
        r0 = 0;
        for (int n = 0; n < FL; n++) r0 += longint'(frame[n]) * longint'(frame[n]);
        for (int k = 0; k < NL; k++) begin
            r = 0;
            for (int n = 0; n + k < FL; n++) r += longint'(frame[n]) * longint'(frame[n + k]);
            if (r0 == 0) begin
                exp_r[k] = (k == 0) ? 32767 : 0;
            end else begin
                mag = ((r < 0 ? -r : r) * 64'sd32768) / r0;
                if (mag > 32767) mag = 32767;
                exp_r[k] = (r < 0) ? -int'(mag) : int'(mag);
            end
        end
    endfunction

    // gap: 0 = back-to-back valid, 1 = random idle cycles on sample_valid
    task automatic send_frame(input int gap);
        int i = 0;
        int budget = FL * 10 + 100;
        int rv_seen = 0;
        while (i < FL && budget > 0) begin
            @(negedge clk);
            budget--;
            if (bus.r_valid) rv_seen++;
            bus.sample_in    = 16'(frame[i]);
            bus.sample_valid = (gap == 0) || ($urandom_range(0, 3) != 0);
            if (bus.sample_valid && bus.sample_ready) begin
                if (i == FL - 1) last_accept = cyc + 1;
                i++;
            end
        end
        if (i < FL) check("fill_timeout", i, FL);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        check("no_rvalid_in_fill", rv_seen, 0);
        check("busy_after_fill", int'(bus.busy), 1);
        check("sready_low_after_fill", int'(bus.sample_ready), 0);
    endtask

    // mode: 0 always ready, 1 random ready, 2 ready held low 5 cycles at each lag
    task automatic recv_frame(input int mode, input int exp_space, input int exp_lat);
        int n = 0;
        int budget = 8000;
        bit fresh = 1'b1;
        int stall = 0;
        int held_v = 0;
        int held_i = 0;
        int prev_acc = 0;
        int d0;
        bit rdy;
        d0 = done_total;
        while (n < NL && budget > 0) begin
            @(negedge clk);
            budget--;
            rdy = 1'b1;
            if (mode == 1) rdy = ($urandom_range(0, 2) != 0);
            if (mode == 2 && bus.r_valid && stall < 5) begin
                rdy = 1'b0;
                stall++;
            end
            bus.r_ready = rdy;
            if (bus.r_valid) begin
                if (fresh) begin
                    held_v = int'(bus.r_out);
                    held_i = int'(bus.r_index);
                    fresh  = 1'b0;
                    if (n == 0 && exp_lat > 0) check("first_latency", cyc - last_accept, exp_lat);
                end else if (mode == 2) begin
                    check("stall_r_out", int'(bus.r_out), held_v);
                    check("stall_r_index", int'(bus.r_index), held_i);
                    check("stall_sample_ready", int'(bus.sample_ready), 0);
                end
                if (rdy) begin
                    got_val[n] = int'(bus.r_out);
                    got_idx[n] = int'(bus.r_index);
                    if (exp_space > 0 && n > 0) check("out_spacing", cyc + 1 - prev_acc, exp_space);
                    prev_acc = cyc + 1;
                    n++;
                    fresh = 1'b1;
                    stall = 0;
                end
            end
        end
        if (n < NL) check("result_timeout", n, NL);
        @(negedge clk);
        bus.r_ready = 1'b0;
        check("busy_low_at_done", int'(bus.busy), 0);
        check("sready_high_at_done", int'(bus.sample_ready), 1);
        repeat (3) @(negedge clk);
        check("done_pulse_count", done_total - d0, 1);
        for (int i = 0; i < n; i++) begin
            check("lag_index", got_idx[i], i);
            check("lag_value", got_val[i], exp_r[i]);
        end
    endtask

    initial begin
        int d_before;
        tbl[0] = '{0, 32767,  32563, 32358, 30720, 18, 1744};
        tbl[1] = '{1, 32767, -32563, 32358, 30720, 18, 1744};
        tbl[2] = '{2, 32767,      0,     0,     0, 18, 1744};
        tbl[3] = '{3, 32767,      0,     0,     0,  2, 1728};

        rst = 1'b1;
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;
        bus.r_ready      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sample_ready", int'(bus.sample_ready), 1);
        check("rst_r_valid", int'(bus.r_valid), 0);
        check("rst_r_out", int'(bus.r_out), 0);
        check("rst_r_index", int'(bus.r_index), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        rst = 1'b0;
        @(negedge clk);

        // Known frames with hand-derived expectations.
        for (int v = 0; v < 4; v++) begin
            build_frame(tbl[v].pat);
            compute_model();
            send_frame(0);
            recv_frame(0, tbl[v].space, tbl[v].lat);
            check("tbl_r0", got_val[0], tbl[v].e0);
            check("tbl_r1", got_val[1], tbl[v].e1);
            check("tbl_r2", got_val[2], tbl[v].e2);
            check("tbl_r10", got_val[10], tbl[v].e10);
        end

        // Output backpressure: 5 stalled cycles at every lag.
        build_frame(4);
        compute_model();
        send_frame(1);
        recv_frame(2, 0, 0);

        // Reset in the middle of lag 4 accumulation, then a clean constant frame.
        build_frame(4);
        send_frame(0);
        repeat (700) @(negedge clk);
        check("busy_before_reset", int'(bus.busy), 1);
        d_before = done_total;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_r_valid", int'(bus.r_valid), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_sample_ready", int'(bus.sample_ready), 1);
        check("midrst_r_out", int'(bus.r_out), 0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_no_done", done_total - d_before, 0);
        build_frame(0);
        compute_model();
        send_frame(0);
        recv_frame(0, 18, 1744);
        check("after_rst_r1", got_val[1], 32563);
        check("after_rst_r10", got_val[10], 30720);

        // Random frames with random gaps and random backpressure.
        for (int t = 0; t < 3; t++) begin
            build_frame((t == 1) ? 5 : 4);
            compute_model();
            send_frame(1);
            recv_frame(1, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/autocorr_frame.md
# autocorr_frame

Frame autocorrelation engine that sits directly upstream of the Levinson-Durbin recursion stage. It buffers one frame of 16-bit signed audio samples and computes lags R0..R10 with a single multiply-accumulate unit. It then normalises each lag to Q15 relative to R0 (R0 → 32767) and streams the 11 results out with a valid/ready handshake, in the order the LDR stage loads them.

## Interface
- FRAME_LEN, 160: samples per frame (≥ ORDER+1, ≤ 256).
- ORDER, 10: highest lag computed; outputs R0..R[ORDER].
- DW, 16: sample and output width, signed.
- ACC_W, 40: accumulator width, signed; must be ≥ 2·DW + ceil(log2 FRAME_LEN).

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- sample_in, in, DW: signed input sample.
- sample_valid, in, 1: sample_in is valid.
- sample_ready, out, 1: block accepts a sample this cycle.
- r_out, out, DW: normalised signed Q15 lag value.
- r_index, out, 4: lag number of r_out (0..ORDER).
- r_valid, out, 1: r_out/r_index valid; held until accepted.
- r_ready, in, 1: downstream accepts the result.
- busy, out, 1: high in MAC, DIV and OUT states.
- done, out, 1: one-cycle pulse after R[ORDER] is accepted.

## Operation
- States: FILL → MAC → DIV → OUT → (DIV for the next lag | FILL).
- FILL: sample_ready=1. Each cycle with valid&&ready writes the sample to frame RAM[wr_ptr] and increments wr_ptr. When sample FRAME_LEN-1 is accepted: wr_ptr←0, lag k←0, next state MAC.
- MAC: for each k, acc = Σ x[n]·x[n+k] for n = 0..FRAME_LEN-1-k. The DW×DW signed product is sign-extended to ACC_W. One product per cycle. At the end of each lag, acc is stored to lag_reg[k] and acc is cleared. After k=ORDER, next state DIV with k←0.
- DIV, restoring fractional divide: rem←|lag_reg[k]|, den←lag_reg[0].
  - Each of 16 iterations: q bit = (rem ≥ den); if set, rem −= den; then rem <<= 1.
  - Result q = floor(|Rk|·2^15 / R0).
  - Saturate q to 32767; apply the sign of Rk, so the output range is ±32767.
- Special case: R0 == 0 (silent frame) skips the divide. Output R0=32767 and Rk=0 for k≥1.
- OUT: r_valid=1 with r_index=k. On r_valid&&r_ready: if k<ORDER, k++ and go to DIV; else pulse done and go to FILL.
- r_out/r_index stay stable while r_valid && !r_ready.
- Samples arriving outside FILL are not accepted (sample_ready=0). The upstream source holds them.

## Timing
- Reset values: sample_ready=1 (state FILL), r_valid=0, r_out=0, r_index=0, busy=0, done=0. Reset also clears wr_ptr, k and acc. Lag registers need no reset.
- Reset mid-operation at any state: abandon the frame immediately and return to FILL. No partial output and no done pulse.
- Frame RAM has a registered read with two read ports (x[n], x[n+k]) and a 1-cycle latency. The multiplier is registered. MAC per lag takes (FRAME_LEN−k)+2 cycles; there is no overlap between lags.
- DIV takes 16 cycles plus 1 sign/saturate cycle. r_valid rises on the following cycle.
- Total, from the last sample accepted to the first r_valid (FRAME_LEN=160, ORDER=10): Σ(162−k) = 1727 MAC cycles, plus 17.
- Zero-backpressure output spacing is one result per 18 cycles.
- busy goes high the cycle after the last sample is accepted. It goes low on the same edge done pulses.

## Structure
- Shared package autocorr_pkg: state enum (FILL, MAC, DIV, OUT), the Q15_MAX=32767 constant, and default FRAME_LEN/ORDER/ACC_W.
- Sub-module: frac_div_serial (ACC_W-bit restoring divider with start/done handshake). Reused for other normalisations in the LPC path.
- Frame buffer is an inferred dual-read-port RAM of FRAME_LEN×DW inside autocorr_frame.

## Test plan
- Constant frame, all samples 1000 → R0=32767; R1=floor(159·32768/160)=32563; R10=30720; done pulses once.
- Alternating +1000/−1000 → R0=32767; R1=−32563; R2=+32358; R10=+30720.
- Impulse: x[0]=1000, rest 0 → R0=32767; R1..R10=0.
- All-zero frame → R0=32767; R1..R10=0; no divide executed (output spacing 2 cycles).
- r_ready held low for 5 cycles at each lag → r_out/r_index stable while stalled; all 11 values still correct and in order; sample_ready=0 throughout.
- Assert rst during MAC of lag 4, then feed a constant-1000 frame → no r_valid before the new frame completes; results match the constant-frame case.
